// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock behind a start/busy/done handshake.
// Optional INV_CIPHER_KEY_LATCH_EN: capture the key schedule at start so keys may change while busy.
module inv_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic                  clks,
   input  logic                  reset,
   input  logic                  start,
   input  logic [0:127]          cipherText,
   input  logic [0:128*(Nr+1)-1] keys,
   output logic                  busy,
   output logic                  done,
   output logic [0:127]          plainText
);

   localparam int KeyBits = 128 * (Nr + 1);

   localparam logic [0:2047] InvSboxTable = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} fsm_t;

   fsm_t               fsmReg, fsmNext;
   logic [3:0]         roundReg, roundNext;
   logic [0:127]       stateReg, stateNext;
   logic [0:127]       plainNext;
   logic               doneReg, doneNext;
   logic [0:KeyBits-1] keySrc;
   logic [0:127]       rk [0:Nr];
   logic [0:127]       shifted, subbed, roundIn, mixed;

   function automatic logic [7:0] invSbox(input logic [7:0] x);
      return InvSboxTable[{x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:31] invMixCol(input logic [0:31] col);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mB [4];
      logic [7:0] mD [4];
      logic [7:0] mE [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[8*i +: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mB[i] = x8[i] ^ x2[i] ^ a[i];
         mD[i] = x8[i] ^ x4[i] ^ a[i];
         mE[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {mE[0] ^ mB[1] ^ mD[2] ^ m9[3],
              m9[0] ^ mE[1] ^ mB[2] ^ mD[3],
              mD[0] ^ m9[1] ^ mE[2] ^ mB[3],
              mB[0] ^ mD[1] ^ m9[2] ^ mE[3]};
   endfunction

`ifdef INV_CIPHER_KEY_LATCH_EN
   logic [0:KeyBits-1] keyReg;

   always_ff @(posedge clks or negedge reset) begin
      if (!reset) begin
         keyReg <= '0;
      end else if (fsmReg == IDLE && start) begin
         keyReg <= keys;
      end
   end

   assign keySrc = keyReg;
`else
   assign keySrc = keys;
`endif

   generate
      for (genvar gi = 0; gi <= Nr; gi++) begin : gRoundKey
         assign rk[gi] = keySrc[128*gi +: 128];
      end

      // Byte b sits at column b/4, row b%4; row r is rotated right by r columns.
      for (genvar gi = 0; gi < 16; gi++) begin : gByte
         localparam int Row    = gi % 4;
         localparam int Col    = gi / 4;
         localparam int SrcCol = (Col - Row + 4) % 4;
         assign shifted[8*gi +: 8] = stateReg[8*(4*SrcCol + Row) +: 8];
         assign subbed[8*gi +: 8]  = invSbox(shifted[8*gi +: 8]);
      end

      for (genvar gi = 0; gi < 4; gi++) begin : gColumn
         assign mixed[32*gi +: 32] = invMixCol(roundIn[32*gi +: 32]);
      end
   endgenerate

   assign roundIn = subbed ^ rk[roundReg];

   always_comb begin
      fsmNext   = fsmReg;
      roundNext = roundReg;
      stateNext = stateReg;
      plainNext = plainText;
      doneNext  = 1'b0;
      case (fsmReg)
         IDLE: begin
            if (start) begin
               // Initial whitening always reads the port: a latched copy is not loaded yet.
               stateNext = cipherText ^ keys[KeyBits-128 +: 128];
               roundNext = 4'(Nr - 1);
               fsmNext   = ROUNDS;
            end
         end
         ROUNDS: begin
            stateNext = mixed;
            roundNext = roundReg - 4'd1;
            if (roundReg == 4'd1) begin
               fsmNext = FINAL;
            end
         end
         FINAL: begin
            plainNext = subbed ^ rk[0];
            doneNext  = 1'b1;
            fsmNext   = IDLE;
         end
         default: begin
            fsmNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clks or negedge reset) begin
      if (!reset) begin
         fsmReg    <= IDLE;
         roundReg  <= 4'd0;
         stateReg  <= '0;
         plainText <= '0;
         doneReg   <= 1'b0;
      end else begin
         fsmReg    <= fsmNext;
         roundReg  <= roundNext;
         stateReg  <= stateNext;
         plainText <= plainNext;
         doneReg   <= doneNext;
      end
   end

   assign busy = (fsmReg != IDLE);
   assign done = doneReg;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: Nk=4/6/8 instances, forward-cipher reference model, done-time scoreboard.
module tb_inv_cipher_iter;

   typedef struct {
      int           inst;
      logic [0:127] pt;
      int           dueCycle;
   } exp_t;

   logic          clks = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    start;
   logic [2:0]    busy;
   logic [2:0]    done;
   logic [0:127]  cipherText [3];
   logic [0:1919] keys [3];
   logic [0:127]  plainText [3];

   logic [7:0]    sbox [256];
   exp_t          expQ [$];
   exp_t          monExp;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   localparam logic [0:255] FipsKey  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:127] FipsPlain = 128'h00112233445566778899aabbccddeeff;

   inv_cipher_iter #(.Nk(4)) dut4 (
      .clks(clks), .reset(reset), .start(start[0]), .cipherText(cipherText[0]),
      .keys(keys[0][0:1407]), .busy(busy[0]), .done(done[0]), .plainText(plainText[0]));
   inv_cipher_iter #(.Nk(6)) dut6 (
      .clks(clks), .reset(reset), .start(start[1]), .cipherText(cipherText[1]),
      .keys(keys[1][0:1663]), .busy(busy[1]), .done(done[1]), .plainText(plainText[1]));
   inv_cipher_iter #(.Nk(8)) dut8 (
      .clks(clks), .reset(reset), .start(start[2]), .cipherText(cipherText[2]),
      .keys(keys[2][0:1919]), .busy(busy[2]), .done(done[2]), .plainText(plainText[2]));

   always #5 clks = ~clks;
   always @(posedge clks) cyc++;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Forward S-box from GF(2^8) inversion plus the affine map.
   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic expandKey(input int d, input logic [0:255] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nk = 4 + 2 * d;
      int nr = nk + 6;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
               t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      keys[d] = '0;
      for (int i = 0; i < 4 * (nr + 1); i++) keys[d][32*i +: 32] = w[i];
   endtask

   function automatic logic [0:127] aesEnc(input logic [0:127] pt, input int d);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [0:127] res;
      int nr = 10 + 2 * d;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ keys[d][8*i +: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
               s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ keys[d][128*r + 8*i +: 8];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   function automatic logic [0:127] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard: every done pops the oldest expectation and checks instance, data and timing.
   always @(negedge clks) begin
      for (int d = 0; d < 3; d++) begin
         if (done[d] === 1'b1) begin
            $display("done inst=%0d cycle=%0d plainText=%h busy=%b", d, cyc, plainText[d], busy[d]);
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: inst=%0d got done=1 expected no done", d);
            end else begin
               monExp = expQ.pop_front();
               if (monExp.inst != d) begin
                  errors++;
                  $display("FAIL done_instance: got %0d expected %0d", d, monExp.inst);
               end
               checks++;
               if (plainText[d] !== monExp.pt) begin
                  errors++;
                  $display("FAIL plaintext: inst=%0d got %h expected %h", d, plainText[d], monExp.pt);
               end
               checks++;
               if (cyc != monExp.dueCycle) begin
                  errors++;
                  $display("FAIL latency: inst=%0d done at cycle %0d expected %0d", d, cyc, monExp.dueCycle);
               end
               checks++;
               if (busy[d] !== 1'b0) begin
                  errors++;
                  $display("FAIL busy_in_done_cycle: inst=%0d got %b expected 0", d, busy[d]);
               end
            end
         end
      end
   end

   // Called at a falling edge; returns one falling edge after the accepting rising edge.
   task automatic startBlock(input int d, input logic [0:127] ct, input logic [0:127] pt);
      exp_t e;
      cipherText[d] = ct;
      start[d] = 1'b1;
      e.inst = d;
      e.pt = pt;
      e.dueCycle = cyc + 11 + 2 * d;
      expQ.push_back(e);
      $display("start inst=%0d cycle=%0d cipherText=%h expect=%h", d, cyc, ct, pt);
      @(negedge clks);
      start[d] = 1'b0;
   endtask

   task automatic waitDone(input int d);
      int n = 0;
      while (done[d] !== 1'b1 && n < 20) begin
         checks++;
         if (busy[d] !== 1'b1) begin
            errors++;
            $display("FAIL busy_while_running: inst=%0d got %b expected 1", d, busy[d]);
         end
         @(negedge clks);
         n++;
      end
      if (done[d] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: inst=%0d got no done expected done within 20 cycles", d);
      end
   endtask

   task automatic checkHeld(input int d, input logic [0:127] pt);
      @(negedge clks);
      checks++;
      if (done[d] !== 1'b0 || busy[d] !== 1'b0) begin
         errors++;
         $display("FAIL after_done: inst=%0d got done=%b busy=%b expected 0 0", d, done[d], busy[d]);
      end
      checks++;
      if (plainText[d] !== pt) begin
         errors++;
         $display("FAIL plaintext_hold: inst=%0d got %h expected %h", d, plainText[d], pt);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clks);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (busy[d] !== 1'b0 || done[d] !== 1'b0 || plainText[d] !== 128'h0) begin
            errors++;
            $display("FAIL reset_state: inst=%0d got busy=%b done=%b pt=%h expected 0 0 0",
                     d, busy[d], done[d], plainText[d]);
         end
      end
      reset = 1'b1;
      repeat (2) @(negedge clks);
   endtask

   task automatic test_known_answer();
      logic [0:127] ct [3];
      ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
      for (int d = 0; d < 3; d++) begin
         expandKey(d, FipsKey);
         startBlock(d, ct[d], FipsPlain);
         waitDone(d);
         checkHeld(d, FipsPlain);
      end
   endtask

   task automatic test_random();
      logic [0:127] pt;
      for (int d = 0; d < 3; d++) begin
         expandKey(d, {rand128(), rand128()});
         for (int k = 0; k < 2; k++) begin
            pt = rand128();
            startBlock(d, aesEnc(pt, d), pt);
            waitDone(d);
            checkHeld(d, pt);
         end
      end
      expandKey(0, FipsKey);
   endtask

   task automatic test_back_to_back();
      logic [0:127] ptA;
      logic [0:127] ptB;
      ptA = rand128();
      ptB = rand128();
      startBlock(0, aesEnc(ptA, 0), ptA);
      waitDone(0);
      startBlock(0, aesEnc(ptB, 0), ptB);
      waitDone(0);
      checkHeld(0, ptB);
   endtask

   task automatic test_ignored_start();
      logic [0:127] pt;
      pt = rand128();
      startBlock(0, aesEnc(pt, 0), pt);
      repeat (3) @(negedge clks);
      cipherText[0] = '1;
      start[0] = 1'b1;
      @(negedge clks);
      start[0] = 1'b0;
      waitDone(0);
      repeat (14) begin
         @(negedge clks);
         checks++;
         if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_done: got done=%b expected 0", done[0]);
         end
      end
   endtask

   task automatic test_input_hold();
      logic [0:127] pt;
      pt = rand128();
      startBlock(0, aesEnc(pt, 0), pt);
      cipherText[0] = '1;
      waitDone(0);
      checkHeld(0, pt);
   endtask

   task automatic test_key_latch();
`ifdef INV_CIPHER_KEY_LATCH_EN
      startBlock(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, FipsPlain);
      keys[0] = '0;
      waitDone(0);
      checkHeld(0, FipsPlain);
      expandKey(0, FipsKey);
`endif
   endtask

   task automatic test_reset_midblock();
      logic [0:127] pt;
      pt = rand128();
      startBlock(0, aesEnc(pt, 0), pt);
      repeat (4) @(negedge clks);
      @(posedge clks);
      #2;
      reset = 1'b0;
      #1;
      void'(expQ.pop_back());
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || plainText[0] !== 128'h0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b pt=%h expected 0 0 0", busy[0], done[0], plainText[0]);
      end
      repeat (2) @(negedge clks);
      reset = 1'b1;
      repeat (14) begin
         @(negedge clks);
         checks++;
         if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL aborted_block: got done=%b busy=%b expected 0 0", done[0], busy[0]);
         end
      end
      pt = rand128();
      startBlock(0, aesEnc(pt, 0), pt);
      waitDone(0);
      checkHeld(0, pt);
   endtask

   initial begin
      start = 3'b000;
      for (int d = 0; d < 3; d++) begin
         cipherText[d] = '0;
         keys[d] = '0;
      end
      buildSbox();
      test_reset();
      test_known_answer();
      test_random();
      test_back_to_back();
      test_ignored_start();
      test_input_hold();
      test_key_latch();
      test_reset_midblock();
      repeat (3) @(negedge clks);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL pending_results: got %0d outstanding expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
